hex_scan_driver: RTL and testbench
==================================

Name: hex_scan_driver

Overview:
- Upstream feeder for the SevenSeg decoder.
- Holds a 16-bit value as four hex digits and time-multiplexes them onto one shared 4-bit nibble bus (nib_o[3]→A, nib_o[2]→B, nib_o[1]→C, nib_o[0]→D).
- Drives one-hot active-high digit enables and the per-digit decimal point.
- New values are double-buffered and committed only at frame boundaries, so a displayed frame never mixes old and new digits.

Parameters:
- TICK_DIV, 100000, clock cycles per digit slot (≥1); 100 MHz gives 1 kHz per digit.
- BLANK_LZ, 1, 1 = blank leading zero digits; 0 = always show all four digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- load_i  input  1  single-cycle strobe; captures value_i and dp_i.
- value_i  input  16  digits: [15:12]=digit3 (MS) … [3:0]=digit0 (LS).
- dp_i  input  4  decimal-point request, bit k ↔ digit k.
- nib_o  output  4  hex nibble of the current digit slot, to decoder A..D.
- an_o  output  4  one-hot digit enable, active-high; 0000 while the slot is blanked.
- dp_o  output  1  decimal point for the current slot.
- pending_o  output  1  a loaded value is waiting in the shadow register.
- frame_o  output  1  one-cycle pulse: a frame boundary just occurred.

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous, active-high. Every register clears immediately on rst assertion, with no clock edge required.
- Reset values:
  - Registers: prescaler=0, idx=0, active=0, shadow=0, active_dp=0, shadow_dp=0, pending=0.
  - Outputs: nib_o=0, an_o=0001, dp_o=0, pending_o=0, frame_o=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 in the cycle where prescaler==TICK_DIV-1.
  - TICK_DIV=1 gives tick every cycle.
- Digit index: idx (2 bits) increments on each tick: 0→1→2→3→0.
- Frame boundary: a tick with idx==3, i.e. the wrap to 0.
- Load:
  - load_i=1 writes value_i/dp_i into shadow/shadow_dp and sets pending.
  - A repeated load before the boundary overwrites the shadow; last value wins.
- Commit at a frame boundary:
  - If pending, active←shadow, active_dp←shadow_dp, pending←0.
  - If load_i coincides with the boundary, value_i/dp_i go straight into active (bypass), and pending ends the cycle at 0.
  - Without a load and with pending=0, active is unchanged.
- frame_o: registered; high for exactly the one cycle after each boundary edge, whether or not a commit happened.
- Outputs:
  - Decoded only from registered state (idx, active, active_dp); no combinational path from any input.
  - nib_o = active[4*idx+3 : 4*idx].
  - dp_o = active_dp[idx] unless the slot is blanked.
  - an_o = one-hot(idx) unless the slot is blanked.
  - nib_o, an_o and dp_o change on the same edge as idx.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k (k=1..3) is blanked iff active digits k..3 are all zero AND active_dp bits k..3 are all zero.
  - Digit 0 is never blanked.
  - Blanked slot: an_o=0000, dp_o=0; nib_o still carries the nibble.
  - With BLANK_LZ=0 no slot is ever blanked.
- pending_o mirrors pending.
- No backpressure: load_i is always accepted.

Test Plan (TICK_DIV=4, BLANK_LZ=1 unless noted):
- Reset release, no load → an_o=0001 for 4 cycles, then 0000 for 12 cycles (digits 1–3 blanked); repeats with period 16; nib_o=0; dp_o=0; frame_o pulses every 16 cycles.
- load_i with value_i=16'h1234, dp_i=0 mid-frame → pending_o=1 and display unchanged until the boundary, then pending_o=0. Next frame shows (nib_o, an_o) = (4,0001), (3,0010), (2,0100), (1,1000), 4 cycles each.
- value_i=16'h0070, dp_i=4'b0100 → frame shows digit0 (0,0001); digit1 (7,0010); digit2 (0,0100) with dp_o=1, unblanked by its DP; digit3 blanked, an_o=0000. Repeat with BLANK_LZ=0 → all four digits enabled.
- Two loads in one frame (16'hAAAA then 16'h5555) → only 5555 is ever displayed; AAAA never appears on nib_o.
- load_i of 16'hBEEF in the exact boundary cycle while pending holds 16'h1111 → next frame shows F,E,E,B; pending_o=0 afterwards; 1111 never displayed.
- Assert rst asynchronously between edges mid-frame with idx=2 → same instant: an_o=0001, nib_o=0, pending_o=0, frame_o=0. After release, the prescaler restarts at 0 (first tick 4 cycles later).

Source files
------------

// File: rtl/hex_scan_driver_if.sv
// Bus between the value producer and the hex scan driver: load strobe, value and
// decimal points in, multiplexed digit outputs and status back.
interface hex_scan_driver_if;
  logic        load_i;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic [3:0]  nib_o;
  logic [3:0]  an_o;
  logic        dp_o;
  logic        pending_o;
  logic        frame_o;

  modport master (
    output load_i, value_i, dp_i,
    input  nib_o, an_o, dp_o, pending_o, frame_o
  );

  modport slave (
    input  load_i, value_i, dp_i,
    output nib_o, an_o, dp_o, pending_o, frame_o
  );
endinterface

// File: rtl/hex_scan_driver.sv
// Four-digit hex scan driver: double-buffered value, one digit slot per tick,
// optional leading-zero blanking, commit only at frame boundaries.
module hex_scan_driver #(
  parameter int unsigned TICK_DIV = 100000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input logic              clk,
  input logic              rst,
  hex_scan_driver_if.slave bus
);

  localparam int unsigned PsW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(TICK_DIV - 1);

  logic [PsW-1:0] r_presc;
  logic [1:0]     r_idx;
  logic [15:0]    r_active;
  logic [15:0]    r_shadow;
  logic [3:0]     r_active_dp;
  logic [3:0]     r_shadow_dp;
  logic           r_pending;
  logic           r_frame;

  logic           w_tick;
  logic           w_boundary;
  logic [3:0]     w_blank;

  assign w_tick     = (r_presc == PsMax);
  assign w_boundary = w_tick && (r_idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_active    <= '0;
      r_shadow    <= '0;
      r_active_dp <= '0;
      r_shadow_dp <= '0;
      r_pending   <= 1'b0;
      r_frame     <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PsW'(1);
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end
      r_frame <= w_boundary;
      if (bus.load_i) begin
        r_shadow    <= bus.value_i;
        r_shadow_dp <= bus.dp_i;
      end
      if (w_boundary) begin
        // A load landing on the boundary itself bypasses the shadow.
        r_pending <= 1'b0;
        if (bus.load_i) begin
          r_active    <= bus.value_i;
          r_active_dp <= bus.dp_i;
        end else if (r_pending) begin
          r_active    <= r_shadow;
          r_active_dp <= r_shadow_dp;
        end
      end else if (bus.load_i) begin
        r_pending <= 1'b1;
      end
    end
  end

  // A digit stays lit if it or any more-significant digit/DP is non-zero.
  always_comb begin
    w_blank = '0;
    if (BLANK_LZ) begin
      w_blank[3] = (r_active[15:12] == 4'd0) && !r_active_dp[3];
      w_blank[2] = w_blank[3] && (r_active[11:8] == 4'd0) && !r_active_dp[2];
      w_blank[1] = w_blank[2] && (r_active[7:4] == 4'd0) && !r_active_dp[1];
    end
  end

  always_comb begin
    bus.nib_o     = r_active[{r_idx, 2'b00} +: 4];
    bus.an_o      = w_blank[r_idx] ? 4'b0000 : (4'b0001 << r_idx);
    bus.dp_o      = r_active_dp[r_idx] && !w_blank[r_idx];
    bus.pending_o = r_pending;
    bus.frame_o   = r_frame;
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver with TICK_DIV=4; a second instance with
// blanking disabled runs on the same stimulus.
module tb_hex_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  hex_scan_driver_if bus();
  hex_scan_driver_if bus_nb();

  hex_scan_driver #(.TICK_DIV(4), .BLANK_LZ(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  hex_scan_driver #(.TICK_DIV(4), .BLANK_LZ(1'b0)) u_dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus_nb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [15:0] val, input logic [3:0] dpm);
    bus.load_i     = ld;
    bus.value_i    = val;
    bus.dp_i       = dpm;
    bus_nb.load_i  = ld;
    bus_nb.value_i = val;
    bus_nb.dp_i    = dpm;
  endtask

  task automatic do_load(input logic [15:0] val, input logic [3:0] dpm);
    drive(1'b1, val, dpm);
    @(negedge clk);
    drive(1'b0, 16'h0000, 4'h0);
  endtask

  // Entered on the first cycle of a frame; checks all 16 cycles of it.
  task automatic check_frame(input string tag, input logic [15:0] val, input logic [3:0] en,
                             input logic [3:0] dpm, input logic pulse);
    for (int i = 0; i < 16; i++) begin
      int k;
      logic [9:0] exp_main;
      logic [8:0] exp_nb;
      k        = i / 4;
      exp_main = {val[4*k +: 4], (en[k] ? (4'b0001 << k) : 4'b0000), en[k] & dpm[k],
                  (i == 0) & pulse};
      exp_nb   = {val[4*k +: 4], (4'b0001 << k), dpm[k]};
      check($sformatf("%s[%0d]", tag, i),
            {22'd0, bus.nib_o, bus.an_o, bus.dp_o, bus.frame_o}, {22'd0, exp_main});
      check($sformatf("%s_nb[%0d]", tag, i),
            {23'd0, bus_nb.nib_o, bus_nb.an_o, bus_nb.dp_o}, {23'd0, exp_nb});
      @(negedge clk);
    end
  endtask

  task automatic wait_frame(input string tag, input logic use_forbid, input logic [3:0] forbid);
    int n;
    n = 0;
    while (bus.frame_o !== 1'b1 && n < 20) begin
      check({tag, "_pend"}, {31'd0, bus.pending_o}, 32'd1);
      if (use_forbid) check({tag, "_forbid"}, {31'd0, bus.nib_o == forbid}, 32'd0);
      @(negedge clk);
      n++;
    end
    check({tag, "_frame"}, {31'd0, bus.frame_o}, 32'd1);
    check({tag, "_pend0"}, {31'd0, bus.pending_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 16'h0000, 4'h0);
    @(negedge clk);
    check("rst_nib",  {28'd0, bus.nib_o}, 32'h0);
    check("rst_an",   {28'd0, bus.an_o}, 32'h1);
    check("rst_dp",   {31'd0, bus.dp_o}, 32'h0);
    check("rst_pend", {31'd0, bus.pending_o}, 32'h0);
    check("rst_frm",  {31'd0, bus.frame_o}, 32'h0);
    rst = 1'b0;
    check_frame("boot0", 16'h0000, 4'b0001, 4'b0000, 1'b0);
    check_frame("boot1", 16'h0000, 4'b0001, 4'b0000, 1'b1);

    // Mid-frame load held in the shadow until the boundary.
    repeat (5) @(negedge clk);
    do_load(16'h1234, 4'b0000);
    check("l1234_pend", {31'd0, bus.pending_o}, 32'd1);
    check("l1234_old",  {28'd0, bus.nib_o}, 32'd0);
    wait_frame("w1234", 1'b0, 4'h0);
    check_frame("v1234", 16'h1234, 4'b1111, 4'b0000, 1'b1);

    // Digit 2 is zero but kept lit by its decimal point.
    repeat (3) @(negedge clk);
    do_load(16'h0070, 4'b0100);
    wait_frame("w0070", 1'b0, 4'h0);
    check_frame("v0070", 16'h0070, 4'b0111, 4'b0100, 1'b1);

    repeat (2) @(negedge clk);
    do_load(16'hAAAA, 4'b0000);
    repeat (3) @(negedge clk);
    do_load(16'h5555, 4'b0000);
    wait_frame("w5555", 1'b1, 4'hA);
    check_frame("v5555", 16'h5555, 4'b1111, 4'b0000, 1'b1);

    // Load in the exact boundary cycle overrides the pending shadow.
    repeat (2) @(negedge clk);
    do_load(16'h1111, 4'b0000);
    check("l1111_pend", {31'd0, bus.pending_o}, 32'd1);
    repeat (12) @(negedge clk);
    do_load(16'hBEEF, 4'b0000);
    check("lbeef_pend", {31'd0, bus.pending_o}, 32'd0);
    check_frame("vbeef", 16'hBEEF, 4'b1111, 4'b0000, 1'b1);

    repeat (8) @(negedge clk);
    do_load(16'h1234, 4'b0000);
    check("pre_rst_nib",  {28'd0, bus.nib_o}, 32'hE);
    check("pre_rst_an",   {28'd0, bus.an_o}, 32'h4);
    check("pre_rst_pend", {31'd0, bus.pending_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_nib",  {28'd0, bus.nib_o}, 32'h0);
    check("arst_an",   {28'd0, bus.an_o}, 32'h1);
    check("arst_dp",   {31'd0, bus.dp_o}, 32'h0);
    check("arst_pend", {31'd0, bus.pending_o}, 32'h0);
    check("arst_frm",  {31'd0, bus.frame_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check_frame("post_rst0", 16'h0000, 4'b0001, 4'b0000, 1'b0);
    check_frame("post_rst1", 16'h0000, 4'b0001, 4'b0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
